cache_line_fill: RTL

Line-fill sequencer that sits directly upstream of the cache's byte-masked word memory. On a miss it bursts one cache line of words from the memory bus, critical word first with wrap-around, and drives the word memory write port (write enable, set index, data, byte mask) one beat per cycle. The critical word is also forwarded to the pipeline so the stalled load can resume before the line completes.

---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_line_fill_wrap_counter.sv | 38 +++
 rtl/cache_line_fill.sv | 106 ++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache line-fill sequencer.
// Holds the fill FSM state encoding, default geometry and the write mask.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DONE
    } fill_state_t;

    localparam int DEF_WORDS      = 16;
    localparam int DEF_BLOCKWORDS = 4;

    localparam logic [3:0] FULL_MASK = 4'b1111;

endpackage

// File: rtl/cache_line_fill_wrap_counter.sv
// Beat offset / beat count tracker for one line burst.
// Ports: clk, reset_n, load+start (begin burst), inc (beat taken),
// off (current word offset), first (no beat yet), last (final beat pending).
module wrap_counter #(
    parameter int BLOCKWORDS = 4,
    parameter int offbits    = $clog2(BLOCKWORDS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [offbits-1:0] start,
    input  logic               inc,
    output logic [offbits-1:0] off,
    output logic               first,
    output logic               last
);

    logic [offbits-1:0] cnt;

    // Offset width equals log2 of the line size, so the natural
    // overflow of the adder is the modulo-BLOCKWORDS wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            off <= '0;
            cnt <= '0;
        end else if (load) begin
            off <= start;
            cnt <= '0;
        end else if (inc) begin
            off <= off + 1'b1;
            cnt <= cnt + 1'b1;
        end
    end

    assign first = (cnt == '0);
    assign last  = (cnt == offbits'(BLOCKWORDS - 1));

endmodule

// File: rtl/cache_line_fill.sv
// Critical-word-first line-fill sequencer driving the word memory write port.
// Ports: miss request in, memory burst bus, word-memory write port, critical word forward.
module cache_line_fill
    import cache_pkg::*;
#(
    parameter int WORDS      = DEF_WORDS,
    parameter int BLOCKWORDS = DEF_BLOCKWORDS,
    parameter int setbits    = $clog2(WORDS),
    parameter int offbits    = $clog2(BLOCKWORDS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               MissReq,
    input  logic [31:0]        MissAddr,
    output logic               Busy,
    output logic               FillDone,
    output logic               BusReq,
    output logic [31:0]        BusAddr,
    input  logic               BusValid,
    input  logic [31:0]        BusRData,
    output logic               WMemWE,
    output logic [setbits-1:0] WMemSet,
    output logic [31:0]        WMemWD,
    output logic [3:0]         WMemByteMask,
    output logic               FwdValid,
    output logic [31:0]        FwdData
);

    fill_state_t        state;
    fill_state_t        state_next;
    logic [29:0]        LineAddr;
    logic [offbits-1:0] Off;
    logic               first;
    logic               last;
    logic               accept;
    logic               beat;
    logic               unused_bits;

    assign unused_bits = ^MissAddr[1:0];

    assign accept = (state == IDLE) && MissReq;
    assign beat   = BusValid && ((state == REQ) || (state == FILL));

    wrap_counter #(
        .BLOCKWORDS(BLOCKWORDS),
        .offbits   (offbits)
    ) u_wrap (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (accept),
        .start  (MissAddr[offbits+1:2]),
        .inc    (beat),
        .off    (Off),
        .first  (first),
        .last   (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            LineAddr <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                LineAddr <= MissAddr[31:2];
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (MissReq) state_next = REQ;
            REQ:  if (beat) state_next = last ? DONE : FILL;
            FILL: if (beat && last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy         = (state != IDLE);
        FillDone     = (state == DONE);
        // Drop the request on the final beat so memory sees no extra cycle.
        BusReq       = ((state == REQ) || (state == FILL)) && !(beat && last);
        BusAddr      = '0;
        WMemWE       = beat;
        WMemSet      = '0;
        WMemWD       = '0;
        WMemByteMask = '0;
        FwdValid     = beat && first;
        FwdData      = '0;
        if (BusReq) begin
            BusAddr = {LineAddr, 2'b00};
        end
        if (beat) begin
            WMemSet      = {LineAddr[setbits-1:offbits], Off};
            WMemWD       = BusRData;
            WMemByteMask = FULL_MASK;
        end
        if (beat && first) begin
            FwdData = BusRData;
        end
    end

endmodule
